// File: rtl/steer_pkg.sv
// Shared widths, limits, FSM encoding and debug view for the steering PI controller.
package steer_pkg;

    localparam int ERR_W    = 12;
    localparam int ESAT_W   = 10;
    localparam int CMD_W    = 11;
    localparam int INT_W    = 15;
    localparam int PT_W     = 14;
    localparam int ADD_W    = 16;

    localparam int ESAT_MAX = 511;
    localparam int ESAT_MIN = -512;
    localparam int CMD_MAX  = 1023;
    localparam int CMD_MIN  = -1023;
    localparam int INT_MAX  = 16383;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_P = 2'd1,
        CALC_I = 2'd2,
        SUM    = 2'd3
    } state_t;

    typedef struct packed {
        state_t             state;
        logic [INT_W-1:0]   integ;
    } steer_dbg_t;

endpackage

// File: rtl/sat_signed.sv
// Signed saturator: clamps a wide signed value into [MIN_V, MAX_V] at a narrower width.
module sat_signed #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 11,
    parameter int MAX_V = 1023,
    parameter int MIN_V = -1023
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(MAX_V);
    localparam logic signed [IN_W-1:0] LO = IN_W'(MIN_V);

    always_comb begin
        if (din > HI) begin
            dout = HI[OUT_W-1:0];
        end else if (din < LO) begin
            dout = LO[OUT_W-1:0];
        end else begin
            dout = din[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/steer_pi.sv
// Steering PI controller: error sample -> P term, saturating integrator, clamped wheel commands.
module steer_pi
    import steer_pkg::*;
#(
    parameter int           P_COEF  = 3,
    parameter logic [10:0]  FWD_SPD = 11'h200,
    parameter int           I_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              err_vld,
    input  logic [ERR_W-1:0]  error,
    output logic [CMD_W-1:0]  lft,
    output logic [CMD_W-1:0]  rht,
    output logic              rdy,
    output steer_dbg_t        dbg
);

    localparam logic signed [PT_W-1:0]  P_COEF_S = PT_W'(P_COEF);
    localparam logic signed [ADD_W-1:0] FWD_EXT  = {{(ADD_W-CMD_W){FWD_SPD[CMD_W-1]}}, FWD_SPD};

    state_t                     state;
    logic signed [ESAT_W-1:0]   err_sat;
    logic signed [PT_W-1:0]     p_term;
    logic signed [INT_W-1:0]    integ;

    logic signed [ESAT_W-1:0]   err_sat_n;
    logic signed [PT_W-1:0]     p_mult;
    logic signed [INT_W-1:0]    i_term;
    logic signed [ADD_W-1:0]    add_a;
    logic signed [ADD_W-1:0]    add_b;
    logic signed [ADD_W-1:0]    add_y;
    logic signed [INT_W-1:0]    integ_n;
    logic signed [INT_W-1:0]    pid;
    logic signed [ADD_W-1:0]    lft_sum;
    logic signed [ADD_W-1:0]    rht_sum;
    logic signed [CMD_W-1:0]    lft_n;
    logic signed [CMD_W-1:0]    rht_n;

    sat_signed #(.IN_W(ERR_W), .OUT_W(ESAT_W), .MAX_V(ESAT_MAX), .MIN_V(ESAT_MIN)) u_sat_err (
        .din  (error),
        .dout (err_sat_n)
    );

    assign p_mult = {{(PT_W-ESAT_W){err_sat[ESAT_W-1]}}, err_sat} * P_COEF_S;
    assign i_term = integ >>> I_SHIFT;

    // One adder serves both the integrator update (CALC_I) and the P+I sum (SUM).
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state == SUM) begin
            add_a = {{(ADD_W-PT_W){p_term[PT_W-1]}}, p_term};
            add_b = {{(ADD_W-INT_W){i_term[INT_W-1]}}, i_term};
        end else begin
            add_a = {{(ADD_W-INT_W){integ[INT_W-1]}}, integ};
            add_b = {{(ADD_W-ESAT_W){err_sat[ESAT_W-1]}}, err_sat};
        end
    end

    assign add_y = add_a + add_b;
    assign pid   = add_y[INT_W-1:0];

    sat_signed #(.IN_W(ADD_W), .OUT_W(INT_W), .MAX_V(INT_MAX), .MIN_V(-INT_MAX)) u_sat_int (
        .din  (add_y),
        .dout (integ_n)
    );

    assign lft_sum = FWD_EXT + {{(ADD_W-INT_W){pid[INT_W-1]}}, pid};
    assign rht_sum = FWD_EXT - {{(ADD_W-INT_W){pid[INT_W-1]}}, pid};

    sat_signed #(.IN_W(ADD_W), .OUT_W(CMD_W), .MAX_V(CMD_MAX), .MIN_V(CMD_MIN)) u_sat_lft (
        .din  (lft_sum),
        .dout (lft_n)
    );

    sat_signed #(.IN_W(ADD_W), .OUT_W(CMD_W), .MAX_V(CMD_MAX), .MIN_V(CMD_MIN)) u_sat_rht (
        .din  (rht_sum),
        .dout (rht_n)
    );

    // Dropping go brakes and aborts any in-flight sample; it outranks a coincident err_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            err_sat <= '0;
            p_term  <= '0;
            integ   <= '0;
            lft     <= '0;
            rht     <= '0;
            rdy     <= 1'b0;
        end else if (!go) begin
            state   <= IDLE;
            integ   <= '0;
            lft     <= '0;
            rht     <= '0;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (err_vld) begin
                        err_sat <= err_sat_n;
                        state   <= CALC_P;
                    end
                end
                CALC_P: begin
                    p_term <= p_mult;
                    state  <= CALC_I;
                end
                CALC_I: begin
                    integ <= integ_n;
                    state <= SUM;
                end
                SUM: begin
                    lft   <= lft_n;
                    rht   <= rht_n;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg = '{state: state, integ: integ};

endmodule

// File: tb/tb_steer_pi.sv
// Self-checking bench for steer_pi: directed scenarios plus randomized samples against a behavioural model.
module tb_steer_pi;
    import steer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        err_vld;
    logic [11:0] error;
    logic [10:0] lft;
    logic [10:0] rht;
    logic        rdy;
    steer_dbg_t  dbg;

    int tests_run;
    int tests_failed;
    int m_integ;

    steer_pi dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .err_vld (err_vld),
        .error   (error),
        .lft     (lft),
        .rht     (rht),
        .rdy     (rdy),
        .dbg     (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Reference model: one accepted sample, default gains (P=3, base 512, I shift 4).
    task automatic model_step(input logic [11:0] e, output logic [10:0] el, output logic [10:0] er);
        int ev;
        int it;
        int pid;
        ev      = clampi(int'($signed(e)), -512, 511);
        m_integ = clampi(m_integ + ev, -16383, 16383);
        it      = (m_integ >= 0) ? (m_integ / 16) : -((15 - m_integ) / 16);
        pid     = 3 * ev + it;
        el      = 11'(clampi(512 + pid, -1023, 1023));
        er      = 11'(clampi(512 - pid, -1023, 1023));
    endtask

    // Drive one sample and watch 8 edges: report first rdy edge index (E = 0), pulse count, outputs.
    task automatic run_sample(input logic [11:0] e, output int lat, output int nrdy,
                              output logic [10:0] l, output logic [10:0] r);
        lat  = -1;
        nrdy = 0;
        l    = 'x;
        r    = 'x;
        @(negedge clk);
        error   = e;
        err_vld = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) err_vld = 1'b0;
            if (rdy === 1'b1) begin
                nrdy++;
                if (lat < 0) begin
                    lat = c;
                    l   = lft;
                    r   = rht;
                end
            end
        end
    endtask

    task automatic brake();
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        m_integ = 0;
    endtask

    task automatic test_reset();
        int nrdy;
        rst_n   = 1'b0;
        go      = 1'b0;
        err_vld = 1'b0;
        error   = '0;
        m_integ = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({lft, rht, rdy} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: lft=%h rht=%h rdy=%b, want 0 0 0", lft, rht, rdy);
        end
        tests_run++;
        if (dbg.state !== IDLE || dbg.integ !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d integ=%0d, want IDLE 0", dbg.state, dbg.integ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        error   = 12'd100;
        err_vld = 1'b1;
        nrdy    = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            err_vld = 1'b0;
            if (rdy === 1'b1) nrdy++;
        end
        tests_run++;
        if (nrdy != 0 || lft !== 11'd0 || rht !== 11'd0 || dbg.integ !== 15'd0) begin
            tests_failed++;
            $display("FAIL go_low_ignore: rdy_pulses=%0d lft=%h rht=%h integ=%0d, want 0 0 0 0",
                     nrdy, lft, rht, dbg.integ);
        end
    endtask

    task automatic test_zero();
        int lat;
        int nrdy;
        logic [10:0] l, r, el, er;
        @(negedge clk);
        go = 1'b1;
        m_integ = 0;
        model_step(12'd0, el, er);
        run_sample(12'd0, lat, nrdy, l, r);
        tests_run++;
        if (lat != 3 || nrdy != 1) begin
            tests_failed++;
            $display("FAIL zero_latency: rdy at edge %0d count %0d, want edge 3 count 1", lat, nrdy);
        end
        tests_run++;
        if (l !== 11'h200 || r !== 11'h200 || l !== el) begin
            tests_failed++;
            $display("FAIL zero_value: lft=%h rht=%h, want 200 200", l, r);
        end
    endtask

    task automatic test_signs();
        int lat;
        int nrdy;
        logic [10:0] l, r, el, er;
        brake();
        tests_run++;
        if (lft !== 11'd0 || rht !== 11'd0) begin
            tests_failed++;
            $display("FAIL go_rise_hold: lft=%h rht=%h, want 0 0", lft, rht);
        end
        model_step(12'd100, el, er);
        run_sample(12'd100, lat, nrdy, l, r);
        tests_run++;
        if (l !== 11'h332 || r !== 11'h0CE || l !== el || r !== er) begin
            tests_failed++;
            $display("FAIL pos_error: lft=%h rht=%h, want 332 0ce", l, r);
        end
        brake();
        model_step(12'hF9C, el, er);
        run_sample(12'hF9C, lat, nrdy, l, r);
        tests_run++;
        if (l !== 11'h0CD || r !== 11'h333 || l !== el || r !== er) begin
            tests_failed++;
            $display("FAIL neg_error: lft=%h rht=%h, want 0cd 333", l, r);
        end
    endtask

    task automatic test_saturation();
        int lat;
        int nrdy;
        logic [10:0] l, r;
        brake();
        run_sample(12'h7FF, lat, nrdy, l, r);
        tests_run++;
        if (l !== 11'h3FF || r !== 11'h401) begin
            tests_failed++;
            $display("FAIL cmd_saturate: lft=%h rht=%h, want 3ff 401", l, r);
        end
        tests_run++;
        if (dbg.integ !== 15'd511) begin
            tests_failed++;
            $display("FAIL err_saturate: integ=%0d, want 511", dbg.integ);
        end
    endtask

    task automatic test_integ_clamp();
        int lat;
        int nrdy;
        int bad;
        logic [10:0] l, r, el, er;
        brake();
        bad = 0;
        for (int n = 1; n <= 40; n++) begin
            model_step(12'd511, el, er);
            run_sample(12'd511, lat, nrdy, l, r);
            if (l !== el || r !== er || lat != 3) bad++;
            if (n == 32) begin
                tests_run++;
                if (dbg.integ !== 15'd16352) begin
                    tests_failed++;
                    $display("FAIL integ_32: integ=%0d, want 16352", dbg.integ);
                end
            end
            if (n == 33 || n == 40) begin
                tests_run++;
                if (dbg.integ !== 15'd16383 || int'($signed(dbg.integ)) != m_integ) begin
                    tests_failed++;
                    $display("FAIL integ_clamp_%0d: integ=%0d, want 16383", n, dbg.integ);
                end
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL clamp_cmds: %0d samples differed from model, want 0", bad);
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        m_integ = 0;
        tests_run++;
        if (dbg.integ !== 15'd0 || lft !== 11'd0 || rht !== 11'd0) begin
            tests_failed++;
            $display("FAIL clamp_brake: integ=%0d lft=%h rht=%h, want 0 0 0", dbg.integ, lft, rht);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_l_q[$];
        logic [10:0] exp_r_q[$];
        logic [10:0] el, er, wl, wr;
        logic [11:0] cur;
        int nrdy;
        int bad;
        brake();
        nrdy = 0;
        bad  = 0;
        @(negedge clk);
        cur     = 12'($urandom_range(0, 4095));
        error   = cur;
        err_vld = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (c % 4 == 0) begin
                model_step(cur, el, er);
                exp_l_q.push_back(el);
                exp_r_q.push_back(er);
            end
            if (rdy === 1'b1) begin
                nrdy++;
                if (c % 4 != 3 || exp_l_q.size() == 0) begin
                    bad++;
                end else begin
                    wl = exp_l_q.pop_front();
                    wr = exp_r_q.pop_front();
                    if (lft !== wl || rht !== wr) bad++;
                end
            end
            cur   = 12'($urandom_range(0, 4095));
            error = cur;
        end
        err_vld = 1'b0;
        tests_run++;
        if (nrdy != 6 || bad != 0) begin
            tests_failed++;
            $display("FAIL back_to_back: rdy_pulses=%0d bad=%0d, want 6 0", nrdy, bad);
        end
    endtask

    task automatic test_abort();
        int nrdy;
        @(negedge clk);
        error   = 12'd200;
        err_vld = 1'b1;
        @(posedge clk);
        #1;
        err_vld = 1'b0;
        @(posedge clk);
        #1;
        go = 1'b0;
        @(posedge clk);
        #1;
        m_integ = 0;
        tests_run++;
        if (lft !== 11'd0 || rht !== 11'd0 || rdy !== 1'b0 || dbg.state !== IDLE || dbg.integ !== 15'd0) begin
            tests_failed++;
            $display("FAIL abort: lft=%h rht=%h rdy=%b state=%0d integ=%0d, want 0 0 0 IDLE 0",
                     lft, rht, rdy, dbg.state, dbg.integ);
        end
        go   = 1'b1;
        nrdy = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (rdy === 1'b1) nrdy++;
        end
        tests_run++;
        if (nrdy != 0 || lft !== 11'd0) begin
            tests_failed++;
            $display("FAIL abort_no_rdy: rdy_pulses=%0d lft=%h, want 0 0", nrdy, lft);
        end
    endtask

    task automatic test_brake_wins();
        int nrdy;
        @(negedge clk);
        go      = 1'b0;
        err_vld = 1'b1;
        error   = 12'd50;
        @(negedge clk);
        go      = 1'b1;
        err_vld = 1'b0;
        m_integ = 0;
        nrdy    = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (rdy === 1'b1) nrdy++;
        end
        tests_run++;
        if (nrdy != 0 || dbg.state !== IDLE || dbg.integ !== 15'd0) begin
            tests_failed++;
            $display("FAIL brake_wins: rdy_pulses=%0d state=%0d integ=%0d, want 0 IDLE 0",
                     nrdy, dbg.state, dbg.integ);
        end
    endtask

    task automatic test_random();
        int lat;
        int nrdy;
        int bad;
        logic [11:0] e;
        logic [10:0] l, r, el, er;
        bad = 0;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) brake();
            e = 12'($urandom_range(0, 4095));
            model_step(e, el, er);
            run_sample(e, lat, nrdy, l, r);
            if (l !== el || r !== er || lat != 3 || nrdy != 1) begin
                bad++;
                if (bad <= 3) $display("FAIL random_sample: error=%h lft=%h rht=%h lat=%0d, want %h %h 3",
                                       e, l, r, lat, el, er);
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL random_total: %0d of 30 samples wrong, want 0", bad);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        error   = 12'd300;
        err_vld = 1'b1;
        @(posedge clk);
        #1;
        err_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (lft !== 11'd0 || rht !== 11'd0 || dbg.state !== IDLE || dbg.integ !== 15'd0) begin
            tests_failed++;
            $display("FAIL async_reset: lft=%h rht=%h state=%0d integ=%0d, want 0 0 IDLE 0",
                     lft, rht, dbg.state, dbg.integ);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_zero();
        test_signs();
        test_saturation();
        test_integ_clamp();
        test_back_to_back();
        test_abort();
        test_brake_wins();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
